// File: rtl/stack_pkg.sv
// stack_pkg: shared encodings for the CPU stack sequencer.
// Op codes, response codes and FSM states.
package stack_pkg;

  localparam logic [1:0] OP_ILL  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;
  localparam logic [1:0] ERR_ILL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUSH_WR = 3'd1,
    S_POP_RD  = 3'd2,
    S_POP_CAP = 3'd3,
    S_RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/stack_depth_cnt.sv
// stack_depth_cnt: entry counter with registered empty/full flags.
// Optional high-water mark under STACK_CTRL_HWM_EN.
module stack_depth_cnt
  import stack_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             empty,
`ifdef STACK_CTRL_HWM_EN
  output logic [CNT_W-1:0] hwm,
`endif
  output logic             full
);

  logic [CNT_W-1:0] count_nxt;

  // Next count; the controller never raises inc and dec together.
  always_comb begin
    count_nxt = count;
    if (inc)
      count_nxt = count + CNT_W'(1);
    else if (dec)
      count_nxt = count - CNT_W'(1);
  end

  // Flags follow count_nxt so they move on the same edge as count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

`ifdef STACK_CTRL_HWM_EN
  // Highest depth reached since reset.
  always_ff @(posedge clk) begin
    if (reset)
      hwm <= '0;
    else if (count_nxt > hwm)
      hwm <= count_nxt;
  end
`endif

endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: push/pop/peek sequencer for the CPU stack.
// Optional hwm output with STACK_CTRL_HWM_EN.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int ADDR_W    = 16,
  parameter      STACK_TOP = 16'hFFFF,
  parameter  int DEPTH     = 256,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [1:0]        resp_code,
  input  logic [ADDR_W-1:0] sp_in,
  output logic              sp_push,
  output logic              sp_pop,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              empty,
  output logic              full,
`ifdef STACK_CTRL_HWM_EN
  output logic [CNT_W-1:0]  hwm,
`endif
  output logic [CNT_W-1:0]  depth
);

  // SP reset value lives in the SP module; only sanity-check it here.
  if (STACK_TOP >= (64'd1 << ADDR_W)) begin : g_bad_top
    $error("STACK_TOP does not fit in ADDR_W");
  end

  state_t            state;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic              wr_cyc;
  logic              rd_cyc;

  stack_depth_cnt #(
    .DEPTH (DEPTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (sp_push),
    .dec   (sp_pop),
    .count (depth),
    .empty (empty),
`ifdef STACK_CTRL_HWM_EN
    .hwm   (hwm),
`endif
    .full  (full)
  );

  // Sequencer: accept, memory access, capture, hold response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= OP_ILL;
      data_q    <= '0;
      resp_data <= '0;
      resp_code <= ERR_NONE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            data_q    <= req_data;
            resp_data <= '0;
            resp_code <= ERR_NONE;
            unique case (req_op)
              OP_PUSH: begin
                if (full) begin
                  resp_code <= ERR_OVF;
                  state     <= S_RESP;
                end else begin
                  state <= S_PUSH_WR;
                end
              end
              OP_POP, OP_PEEK: begin
                if (empty) begin
                  resp_code <= ERR_UNF;
                  state     <= S_RESP;
                end else begin
                  state <= S_POP_RD;
                end
              end
              default: begin
                resp_code <= ERR_ILL;
                state     <= S_RESP;
              end
            endcase
          end
        end
        S_PUSH_WR: state <= S_RESP;
        S_POP_RD:  state <= S_POP_CAP;
        S_POP_CAP: begin
          resp_data <= mem_rdata;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are masked by reset so an aborted sequence issues nothing.
  always_comb begin
    wr_cyc    = (state == S_PUSH_WR) && !reset;
    rd_cyc    = (state == S_POP_RD) && !reset;
    sp_push   = wr_cyc;
    sp_pop    = rd_cyc && (op_q == OP_POP);
    mem_we    = wr_cyc;
    mem_re    = rd_cyc;
    mem_wdata = wr_cyc ? data_q : '0;
    mem_addr  = '0;
    if (wr_cyc)
      mem_addr = sp_in;
    else if (rd_cyc)
      mem_addr = sp_in + ADDR_W'(1);
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
    resp_err   = (resp_code != ERR_NONE);
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequencer for the CPU stack. Accepts push/pop/peek requests from the control unit over a valid/ready handshake.
- Drives the SP register's push/pop strobes and the data-memory port.
- Returns popped/peeked data with error status.
- Tracks stack depth for full/empty and overflow/underflow detection. Sits between the control unit, the SP register and data memory.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, SP / memory address width
STACK_TOP, 16'hFFFF, SP value at reset (first free slot); stack grows downward
DEPTH, 256, maximum number of entries; CNT_W = $clog2(DEPTH+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_op  in  2  01 push, 10 pop, 11 peek, 00 illegal
req_data  in  DATA_W  push data
resp_valid  out  1  response present
resp_ready  in  1  response consumed
resp_data  out  DATA_W  pop/peek data; 0 for push/error
resp_err  out  1  request failed
resp_code  out  2  00 ok, 01 overflow, 10 underflow, 11 illegal op
sp_in  in  ADDR_W  current SP value (points at next free slot)
sp_push  out  1  one-cycle strobe; SP decrements next edge
sp_pop  out  1  one-cycle strobe; SP increments next edge
mem_addr  out  ADDR_W  memory address
mem_we  out  1  write enable
mem_re  out  1  read enable; sync read, rdata valid 1 cycle later
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data
empty  out  1  count == 0
full  out  1  count == DEPTH
depth  out  CNT_W  current entry count

Behaviour:
- Reset state: IDLE, count=0, all strobes/enables 0, resp_valid=0, resp_data=0, resp_code=00, mem_addr=0, mem_wdata=0.
- Reset mid-operation aborts any sequence; no strobe is issued in the reset cycle.
- States: IDLE, PUSH_WR, POP_RD, POP_CAP, RESP.
- IDLE: req_ready=1. On req_valid, latch op and data, then:
  - push: full -> RESP err 01; else PUSH_WR.
  - pop: empty -> RESP err 10; else POP_RD.
  - peek: empty -> RESP err 10; else POP_RD with no SP change.
  - op 00 -> RESP err 11.
- PUSH_WR (1 cycle): mem_addr=sp_in, mem_we=1, mem_wdata=latched data, sp_push=1, count+1 -> RESP.
- POP_RD (1 cycle): mem_addr=sp_in+1 (mod 2^ADDR_W), mem_re=1.
  - pop: sp_pop=1, count-1.
  - peek: no strobe, count unchanged.
  - -> POP_CAP.
- POP_CAP: capture mem_rdata into resp_data -> RESP.
- RESP: resp_valid=1 and held stable until resp_ready; on resp_ready -> IDLE. A new request can be accepted no earlier than the cycle after the handshake.
- Latency from accept cycle T to resp_valid: push T+2, pop/peek T+3, error T+1.
- Errors: no SP strobe, no memory access, count unchanged.
- sp_push and sp_pop are never high in the same cycle; never both mem_we and mem_re.
- empty/full/depth are registered from count and update the cycle after the strobe.
- Count saturation cannot occur because of the full/empty checks. SP arithmetic is owned by the SP module; the controller does not check sp_in against STACK_TOP.

Optional Feature:
- STACK_CTRL_HWM_EN defined: adds output hwm [CNT_W], the high-water mark of count since reset. Updated the same cycle as count (hwm <= max(hwm, count_next)); reset to 0.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package stack_pkg holds:
  - op encodings (OP_PUSH, OP_POP, OP_PEEK, OP_ILL)
  - error codes (ERR_NONE, ERR_OVF, ERR_UNF, ERR_ILL)
  - FSM state enum
- One sub-module, stack_depth_cnt:
  - inputs: inc, dec, reset
  - outputs: count, empty, full
  - includes hwm under the macro.
- FSM and memory/SP drive stay in stack_ctrl.

Test Plan:
- Reset, then push 16'hA5A5 with sp_in=16'hFFFF -> T+1 mem_we=1 at addr 16'hFFFF with wdata A5A5, sp_push=1; T+2 resp_valid with err=0; depth=1.
- Follow with pop (sp_in=16'hFFFE) -> T+1 mem_re at addr 16'hFFFF, sp_pop=1; T+3 resp_data=16'hA5A5; empty=1.
- Pop when empty -> T+1 resp_err=1 with code 10; no sp_pop, mem_re, or count change.
- DEPTH=4: five pushes -> first four ok, full=1; fifth returns code 01 with no mem_we.
- Peek after pushing 16'h1234 -> resp_data=16'h1234; depth unchanged; no sp strobe. Then op 00 -> code 11.
- Hold resp_ready=0 for 3 cycles -> resp_valid and resp_data stable, req_ready=0. Assert reset during POP_CAP -> next cycle IDLE, depth=0, resp_valid=0. With STACK_CTRL_HWM_EN, hwm=4 after the DEPTH=4 run.
